// File: rtl/db9_md_scanner.sv
// Sega Mega Drive 3/6-button pad scanner for a DB9 port: eight select phases, then an idle gap.
// Build option DB9_SPLITTER_EN: alternate scans between two splitter ports, starting with port 1.
module db9_md_scanner #(
  parameter int SEL_PHASE_CLKS = 400,
  parameter int IDLE_CLKS      = 64000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [5:0]  joy_db9_n,
  output logic        db9_select,
  output logic        splitter_select,
  output logic [11:0] joy1_n,
  output logic [11:0] joy2_n,
  output logic        pad6_1,
  output logic        pad6_2,
  output logic        frame_done
);

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  localparam logic [15:0] SEL_LAST  = 16'(SEL_PHASE_CLKS - 1);
  localparam logic [15:0] IDLE_LAST = 16'(IDLE_CLKS - 1);

  logic [5:0]  sync1_q, sync2_q;
  state_t      state_q;
  logic [2:0]  phase_q;
  logic [2:0]  phase_d;
  logic [15:0] cnt_q;
  logic [11:0] word_q;
  logic        present_q, six_q;
  logic        sel_q, split_q, done_q;
  logic [11:0] joy1_q, joy2_q;
  logic        pad6_1_q, pad6_2_q;
  logic [11:0] commit_word_d;
  logic        commit_six_d;
  logic        u_n, d_n, l_n, r_n;

  assign {u_n, d_n, l_n, r_n} = sync2_q[3:0];
  assign phase_d = phase_q + 3'd1;

  // Word actually published at the end of phase 7; masks bits the pad did not report.
  always_comb begin
    commit_word_d = 12'hFFF;
    commit_six_d  = 1'b0;
    if (present_q) begin
      commit_word_d = six_q ? word_q : {4'hF, word_q[7:0]};
      commit_six_d  = six_q;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 6'h3F;
      sync2_q <= 6'h3F;
    end else begin
      sync1_q <= joy_db9_n;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= 3'd0;
      cnt_q     <= 16'd0;
      word_q    <= 12'hFFF;
      present_q <= 1'b0;
      six_q     <= 1'b0;
      sel_q     <= 1'b1;
      split_q   <= 1'b1;
      done_q    <= 1'b0;
      joy1_q    <= 12'hFFF;
      joy2_q    <= 12'hFFF;
      pad6_1_q  <= 1'b0;
      pad6_2_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cnt_q == IDLE_LAST) begin
            state_q <= ST_SCAN;
            cnt_q   <= 16'd0;
            phase_q <= 3'd0;
            sel_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_SCAN: begin
          if (cnt_q != SEL_LAST) begin
            cnt_q <= cnt_q + 16'd1;
          end else begin
            cnt_q <= 16'd0;
            case (phase_q)
              3'd0: word_q[5:0] <= {sync2_q[5:4], r_n, l_n, d_n, u_n};
              3'd1: begin
                word_q[7:6] <= sync2_q[5:4];
                present_q   <= ~l_n & ~r_n;
              end
              3'd5: six_q <= ~(u_n | d_n | l_n | r_n);
              3'd6: word_q[11:8] <= {r_n, l_n, d_n, u_n};
              default: ;
            endcase
            if (phase_q == 3'd7) begin
              state_q <= ST_IDLE;
              phase_q <= 3'd0;
              sel_q   <= 1'b1;
              done_q  <= 1'b1;
`ifdef DB9_SPLITTER_EN
              split_q <= ~split_q;
              if (split_q) begin
                joy1_q   <= commit_word_d;
                pad6_1_q <= commit_six_d;
              end else begin
                joy2_q   <= commit_word_d;
                pad6_2_q <= commit_six_d;
              end
`else
              joy1_q   <= commit_word_d;
              pad6_1_q <= commit_six_d;
`endif
            end else begin
              phase_q <= phase_d;
              sel_q   <= ~phase_d[0];
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign db9_select      = sel_q;
  assign splitter_select = split_q;
  assign joy1_n          = joy1_q;
  assign joy2_n          = joy2_q;
  assign pad6_1          = pad6_1_q;
  assign pad6_2          = pad6_2_q;
  assign frame_done      = done_q;

endmodule
